mem_map_io: RTL and testbench

- Parametrised successor to the CPU data-memory map: one RAM window plus IO_CH memory-mapped IO registers plus a status word, on the CPU's writeM/addressM/outM-style bus.
- Reads are registered (1-cycle latency, valid strobe).
- Each IO register can also be loaded by hardware (buttons, UART RX, SPI), with sticky per-channel "updated" flags that clear when the status word is read.
- Sits between the CPU core and the peripheral blocks.

---
 rtl/mem_map_io.sv | 164 ++++++++++++++++
 tb/tb_mem_map_io.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_io.sv
// CPU data-memory map: RAM window, IO_CH memory-mapped IO registers with hardware load, and a sticky status word.
// Optional build macro MEM_ADDR_ERR_EN adds the addr_err output for unmapped accesses.
module mem_map_io #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int RAM_DEPTH = 3840,
    parameter int IO_BASE   = 3840,
    parameter int IO_CH     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_we,
    input  logic                    mem_re,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W-1:0]       mem_rdata,
    output logic                    mem_rvalid,
    output logic [IO_CH*DATA_W-1:0] io_out,
    output logic [IO_CH-1:0]        io_wstb,
    input  logic [IO_CH-1:0]        hw_we,
    input  logic [IO_CH*DATA_W-1:0] hw_wdata
`ifdef MEM_ADDR_ERR_EN
    ,
    output logic                    addr_err
`endif
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [31:0] RAM_END   = 32'(RAM_DEPTH);
    localparam logic [31:0] STAT_ADDR = 32'(IO_BASE + IO_CH);

    logic [31:0]                   addrW;
    logic                          isRam;
    logic                          isStatus;
    logic                          isIo;
    logic                          unmapped;
    logic [IO_CH-1:0]              ioSel;
    logic [IO_CH-1:0]              cpuWr;
    logic [RAM_AW-1:0]             ramIdx;
    logic                          ramWe;
    logic [DATA_W-1:0]             ioRd;
    logic [DATA_W-1:0]             statusWord;
    logic [DATA_W-1:0]             regRd;
    logic [IO_CH-1:0]              clrMask;

    logic [DATA_W-1:0]             ram [RAM_DEPTH];
    logic [IO_CH-1:0][DATA_W-1:0]  ioReg;
    logic [IO_CH-1:0]              flags;

    logic [DATA_W-1:0]             rdRam_p1;
    logic [DATA_W-1:0]             rdReg_p1;
    logic                          rdSelRam_p1;
    logic                          vld_p1;
    logic [IO_CH-1:0]              wstb_p1;
    logic                          addrErr_p1;

    // Stage 0: full-width address decode and register-side read mux
    assign addrW    = 32'(mem_addr);
    assign isRam    = (addrW < RAM_END);
    assign isStatus = (addrW == STAT_ADDR);
    assign isIo     = |ioSel;
    assign unmapped = ~isRam & ~isIo & ~isStatus;
    assign ramIdx   = mem_addr[RAM_AW-1:0];
    assign ramWe    = mem_we & isRam & rst_n;
    assign cpuWr    = {IO_CH{mem_we}} & ioSel;
    assign clrMask  = {IO_CH{mem_re & isStatus}};

    always_comb begin
        ioSel = '0;
        ioRd  = '0;
        for (int i = 0; i < IO_CH; i++) begin
            ioSel[i] = (addrW == 32'(IO_BASE + i));
            if (ioSel[i]) begin
                ioRd = ioRd | ioReg[i];
            end
        end
    end

    always_comb begin
        statusWord              = '0;
        statusWord[IO_CH-1:0]   = flags;
    end

    always_comb begin
        regRd = '0;
        if (isIo) begin
            regRd = ioRd;
        end else if (isStatus) begin
            regRd = statusWord;
        end
    end

    // RAM has no reset; the read port samples before the write lands (read-before-write)
    always_ff @(posedge clk) begin
        if (mem_re && isRam) begin
            rdRam_p1 <= ram[ramIdx];
        end
        if (ramWe) begin
            ram[ramIdx] <= mem_wdata;
        end
    end

    // Stage 1: registered read response, IO state, strobes and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdReg_p1    <= '0;
            rdSelRam_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= mem_re;
            if (mem_re) begin
                rdReg_p1    <= regRd;
                rdSelRam_p1 <= isRam;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ioReg   <= '0;
            wstb_p1 <= '0;
        end else begin
            for (int i = 0; i < IO_CH; i++) begin
                if (hw_we[i]) begin
                    ioReg[i] <= hw_wdata[i*DATA_W +: DATA_W];
                end else if (cpuWr[i]) begin
                    ioReg[i] <= mem_wdata;
                end
            end
            // A colliding hardware load suppresses the CPU strobe
            wstb_p1 <= cpuWr & ~hw_we;
        end
    end

    // Set beats clear when a hardware load coincides with a status read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~clrMask) | hw_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrErr_p1 <= 1'b0;
        end else begin
            addrErr_p1 <= (mem_we | mem_re) & unmapped;
        end
    end

    assign mem_rdata  = rdSelRam_p1 ? rdRam_p1 : rdReg_p1;
    assign mem_rvalid = vld_p1;
    assign io_out     = ioReg;
    assign io_wstb    = wstb_p1;

`ifdef MEM_ADDR_ERR_EN
    assign addr_err = addrErr_p1;
`else
    logic unusedAddrErr;
    assign unusedAddrErr = addrErr_p1;
`endif

endmodule

// File: tb/tb_mem_map_io.sv
// Directed self-checking bench for mem_map_io (default parameters).
module tb_mem_map_io;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int IO_CH  = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    mem_we;
    logic                    mem_re;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_rvalid;
    logic [IO_CH*DATA_W-1:0] io_out;
    logic [IO_CH-1:0]        io_wstb;
    logic [IO_CH-1:0]        hw_we;
    logic [IO_CH*DATA_W-1:0] hw_wdata;
`ifdef MEM_ADDR_ERR_EN
    logic                    addr_err;
`endif

    int nCmp = 0;
    int nErr = 0;
    logic [IO_CH*DATA_W-1:0] expIo;

    mem_map_io dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .io_out    (io_out),
        .io_wstb   (io_wstb),
        .hw_we     (hw_we),
        .hw_wdata  (hw_wdata)
`ifdef MEM_ADDR_ERR_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        hw_we     = '0;
        hw_wdata  = '0;
        expIo     = '0;
        tick();
        tick();
        chk("rst_rvalid", 256'(mem_rvalid), 256'(0));
        chk("rst_rdata", 256'(mem_rdata), 256'(0));
        chk("rst_io_out", 256'(io_out), 256'(0));
        chk("rst_wstb", 256'(io_wstb), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reads of an IO channel and the status word after reset
        mem_re = 1'b1; mem_addr = 16'd3843;
        tick();
        mem_re = 1'b0;
        chk("io3_rvalid", 256'(mem_rvalid), 256'(1));
        chk("io3_rdata", 256'(mem_rdata), 256'(16'h0000));
        tick();
        chk("idle_rvalid", 256'(mem_rvalid), 256'(0));
        mem_re = 1'b1; mem_addr = 16'd3856;
        tick();
        mem_re = 1'b0;
        chk("stat0_rvalid", 256'(mem_rvalid), 256'(1));
        chk("stat0_rdata", 256'(mem_rdata), 256'(16'h0000));

        // RAM write then read, then read-before-write
        mem_we = 1'b1; mem_addr = 16'h0123; mem_wdata = 16'hBEEF;
        tick();
        mem_we = 1'b0; mem_re = 1'b1;
        tick();
        chk("ram_rvalid", 256'(mem_rvalid), 256'(1));
        chk("ram_rdata", 256'(mem_rdata), 256'(16'hBEEF));
        mem_we = 1'b1; mem_wdata = 16'h1234;
        tick();
        mem_we = 1'b0;
        chk("rbw_old", 256'(mem_rdata), 256'(16'hBEEF));
        tick();
        mem_re = 1'b0;
        chk("rbw_new", 256'(mem_rdata), 256'(16'h1234));
        tick();
        chk("hold_rvalid", 256'(mem_rvalid), 256'(0));
        chk("hold_rdata", 256'(mem_rdata), 256'(16'h1234));

        // RAM top word
        mem_we = 1'b1; mem_addr = 16'd3839; mem_wdata = 16'h3C3C;
        tick();
        mem_we = 1'b0; mem_re = 1'b1;
        tick();
        mem_re = 1'b0;
        chk("ram_top", 256'(mem_rdata), 256'(16'h3C3C));

        // CPU write to IO channel 0
        mem_we = 1'b1; mem_addr = 16'd3840; mem_wdata = 16'h00A5;
        tick();
        mem_we = 1'b0;
        expIo[0*16 +: 16] = 16'h00A5;
        chk("io0_out", 256'(io_out), 256'(expIo));
        chk("io0_wstb", 256'(io_wstb), 256'(16'h0001));
`ifdef MEM_ADDR_ERR_EN
        chk("io0_noerr", 256'(addr_err), 256'(0));
`endif
        tick();
        chk("io0_wstb_off", 256'(io_wstb), 256'(16'h0000));

        // Hardware load on channel 1 and sticky flag
        hw_we = 16'h0002; hw_wdata[1*16 +: 16] = 16'h0042;
        tick();
        hw_we = '0;
        expIo[1*16 +: 16] = 16'h0042;
        chk("hw1_out", 256'(io_out), 256'(expIo));
        chk("hw1_wstb", 256'(io_wstb), 256'(16'h0000));
        mem_re = 1'b1; mem_addr = 16'd3841;
        tick();
        chk("hw1_rdata", 256'(mem_rdata), 256'(16'h0042));
        mem_addr = 16'd3856;
        tick();
        chk("stat1_rdata", 256'(mem_rdata), 256'(16'h0002));
        tick();
        mem_re = 1'b0;
        chk("stat1_clr", 256'(mem_rdata), 256'(16'h0000));

        // CPU write and hardware load collide on channel 2
        mem_we = 1'b1; mem_addr = 16'd3842; mem_wdata = 16'h1111;
        hw_we = 16'h0004; hw_wdata[2*16 +: 16] = 16'h2222;
        tick();
        mem_we = 1'b0; hw_we = '0;
        expIo[2*16 +: 16] = 16'h2222;
        chk("coll_out", 256'(io_out), 256'(expIo));
        chk("coll_wstb", 256'(io_wstb), 256'(16'h0000));
        mem_re = 1'b1; mem_addr = 16'd3856; hw_we = 16'h0004;
        tick();
        hw_we = '0;
        chk("setclr_rd1", 256'(mem_rdata), 256'(16'h0004));
        tick();
        chk("setclr_rd2", 256'(mem_rdata), 256'(16'h0004));
        tick();
        mem_re = 1'b0;
        chk("setclr_rd3", 256'(mem_rdata), 256'(16'h0000));

        // Status write is ignored while the read proceeds
        mem_re = 1'b1; mem_we = 1'b1; mem_addr = 16'd3856; mem_wdata = 16'hFFFF;
        tick();
        mem_re = 1'b0; mem_we = 1'b0;
        chk("statwr_rd", 256'(mem_rdata), 256'(16'h0000));
        chk("statwr_io", 256'(io_out), 256'(expIo));
        chk("statwr_wstb", 256'(io_wstb), 256'(16'h0000));
`ifdef MEM_ADDR_ERR_EN
        chk("statwr_noerr", 256'(addr_err), 256'(0));
`endif

        // Top IO channel decodes
        mem_we = 1'b1; mem_addr = 16'd3855; mem_wdata = 16'h7777;
        tick();
        mem_we = 1'b0;
        expIo[15*16 +: 16] = 16'h7777;
        chk("io15_out", 256'(io_out), 256'(expIo));
        chk("io15_wstb", 256'(io_wstb), 256'(16'h8000));

        // Unmapped write and reads
        mem_we = 1'b1; mem_addr = 16'd3857; mem_wdata = 16'hDEAD;
        tick();
        mem_we = 1'b0;
        chk("unm_wr_io", 256'(io_out), 256'(expIo));
        chk("unm_wr_wstb", 256'(io_wstb), 256'(16'h0000));
`ifdef MEM_ADDR_ERR_EN
        chk("unm_wr_err", 256'(addr_err), 256'(1));
`endif
        tick();
`ifdef MEM_ADDR_ERR_EN
        chk("unm_wr_err_off", 256'(addr_err), 256'(0));
`endif
        mem_re = 1'b1; mem_addr = 16'd3857;
        tick();
        mem_re = 1'b0;
        chk("unm_rd_vld", 256'(mem_rvalid), 256'(1));
        chk("unm_rd_data", 256'(mem_rdata), 256'(16'h0000));
`ifdef MEM_ADDR_ERR_EN
        chk("unm_rd_err", 256'(addr_err), 256'(1));
`endif
        mem_re = 1'b1; mem_addr = 16'hFF00;
        tick();
        mem_re = 1'b0;
        chk("unm_hi_data", 256'(mem_rdata), 256'(16'h0000));

        // Reset during an access aborts it; RAM survives
        mem_we = 1'b1; mem_addr = 16'h0124; mem_wdata = 16'hAAAA;
        tick();
        mem_we = 1'b0;
        mem_re = 1'b1; mem_we = 1'b1; mem_wdata = 16'h5555;
        rst_n = 1'b0;
        tick();
        chk("rstmid_vld", 256'(mem_rvalid), 256'(0));
        chk("rstmid_io", 256'(io_out), 256'(0));
        mem_re = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstrel_vld", 256'(mem_rvalid), 256'(0));
        chk("rstrel_rdata", 256'(mem_rdata), 256'(0));
        mem_re = 1'b1; mem_addr = 16'h0124;
        tick();
        mem_addr = 16'h0123;
        chk("rst_nowrite", 256'(mem_rdata), 256'(16'hAAAA));
        tick();
        mem_addr = 16'd3856;
        chk("rst_ramkeep", 256'(mem_rdata), 256'(16'h1234));
        tick();
        mem_re = 1'b0;
        chk("rst_flags", 256'(mem_rdata), 256'(16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
